// File: rtl/axi_txn_sched_pkg.sv
// rtl/axi_txn_sched_pkg.sv - shared state encoding and default sizing for the AXI transaction scheduler
package axi_txn_sched_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 512;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Request/grant bit positions shared by the arbiter and the scheduler.
    localparam int SIDE_WR = 0;
    localparam int SIDE_RD = 1;

endpackage

// File: rtl/axi_txn_scheduler_rr_arb2.sv
// rtl/axi_txn_scheduler_rr_arb2.sv - two-way round-robin arbiter with a one-bit last-grant pointer
module rr_arb2
    import axi_txn_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // Remembers whether the read side won last; reset as if read won so write wins the first tie.
    logic last_rd;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_rd ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_rd <= 1'b1;
        end else if (update) begin
            last_rd <= gnt[SIDE_RD];
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// rtl/axi_txn_scheduler.sv - one-at-a-time write/read burst scheduler in front of an AXI master
// Optional watchdog in WAIT enabled by defining AXI_TXN_SCHED_TIMEOUT_EN.
module axi_txn_scheduler
    import axi_txn_sched_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              m00_axi_aclk,
    input  logic              m00_axi_areset,
    input  logic              wr_req_valid,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              wr_req_ready,
    input  logic              rd_req_valid,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_req_ready,
    output logic              start_write_txn,
    output logic              start_read_txn,
    output logic [ADDR_W-1:0] write_base_addr,
    output logic [ADDR_W-1:0] read_base_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              txn_done,
    input  logic              txn_error,
    output logic              rsp_valid,
    output logic              rsp_is_read,
    output logic              rsp_error,
    output logic              busy,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi_txn_scheduler: TIMEOUT_CYCLES must be at least 2");
    end

    state_e     state;
    logic       side_rd;
    logic       err_q;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       grant;
    logic       timeout_hit;

    // Requests are only visible to the arbiter in IDLE; elsewhere they simply wait.
    assign req   = {rd_req_valid, wr_req_valid} & {2{(state == ST_IDLE) && !m00_axi_areset}};
    assign grant = |gnt;

    rr_arb2 u_arb (
        .clk    (m00_axi_aclk),
        .reset  (m00_axi_areset),
        .req    (req),
        .update (grant),
        .gnt    (gnt)
    );

    assign wr_req_ready    = gnt[SIDE_WR];
    assign rd_req_ready    = gnt[SIDE_RD];
    assign start_write_txn = (state == ST_ISSUE) && !side_rd;
    assign start_read_txn  = (state == ST_ISSUE) && side_rd;
    assign rsp_valid       = (state == ST_RESP);
    assign rsp_is_read     = rsp_valid && side_rd;
    assign rsp_error       = rsp_valid && err_q;
    assign busy            = (state != ST_IDLE);

`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    // A completion in the same cycle as the last watchdog tick wins over the timeout.
    assign timeout_hit = (state == ST_WAIT) && !txn_done &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state           <= ST_IDLE;
            side_rd         <= 1'b0;
            err_q           <= 1'b0;
            write_base_addr <= '0;
            read_base_addr  <= '0;
            write_data      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state   <= ST_ISSUE;
                        side_rd <= gnt[SIDE_RD];
                        err_q   <= 1'b0;
                        if (gnt[SIDE_WR]) begin
                            write_base_addr <= wr_req_addr;
                            write_data      <= wr_req_data;
                        end else begin
                            read_base_addr  <= rd_req_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (txn_done) begin
                        err_q <= txn_error;
                        state <= ST_RESP;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// tb/tb_axi_txn_scheduler.sv - scoreboard bench for axi_txn_scheduler
module tb_axi_txn_scheduler;

    localparam int AW = 32;
    localparam int DW = 512;
    localparam int TO = 16;

    localparam int K_START_W = 0;
    localparam int K_START_R = 1;
    localparam int K_RSP     = 2;

    typedef struct {
        int              kind;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic            is_read;
        logic            err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          wr_req_ready;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic          rd_req_ready;
    logic          start_write_txn;
    logic          start_read_txn;
    logic [AW-1:0] write_base_addr;
    logic [AW-1:0] read_base_addr;
    logic [DW-1:0] write_data;
    logic          txn_done;
    logic          txn_error;
    logic          rsp_valid;
    logic          rsp_is_read;
    logic          rsp_error;
    logic          busy;
    logic          timeout_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_kind;

    axi_txn_scheduler #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_areset  (rst),
        .wr_req_valid    (wr_req_valid),
        .wr_req_addr     (wr_req_addr),
        .wr_req_data     (wr_req_data),
        .wr_req_ready    (wr_req_ready),
        .rd_req_valid    (rd_req_valid),
        .rd_req_addr     (rd_req_addr),
        .rd_req_ready    (rd_req_ready),
        .start_write_txn (start_write_txn),
        .start_read_txn  (start_read_txn),
        .write_base_addr (write_base_addr),
        .read_base_addr  (read_base_addr),
        .write_data      (write_data),
        .txn_done        (txn_done),
        .txn_error       (txn_error),
        .rsp_valid       (rsp_valid),
        .rsp_is_read     (rsp_is_read),
        .rsp_error       (rsp_error),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_watchdog: bench did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.is_read = 1'b0; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_rsp(input logic is_read, input logic err);
        exp_t e;
        e.kind = K_RSP; e.addr = '0; e.data = '0; e.is_read = is_read; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        wr_req_addr = '0; rd_req_addr = '0; wr_req_data = '0;
        txn_done = 1'b0; txn_error = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
    endtask

    // Called in WAIT; leaves the DUT back in IDLE.
    task automatic complete(input logic err);
        txn_done = 1'b1; txn_error = err;
        tick;
        txn_done = 1'b0; txn_error = 1'b0;
        tick;
    endtask

    // Monitor: every start pulse and response must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (start_write_txn || start_read_txn || rsp_valid)) begin
            mon_kind = start_write_txn ? K_START_W : (start_read_txn ? K_START_R : K_RSP);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: kind %0d seen, none expected", mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", DW'(mon_kind), DW'(mon_e.kind));
                if (mon_kind == mon_e.kind) begin
                    if (mon_kind == K_START_W) begin
                        chk("write_base_addr", DW'(write_base_addr), DW'(mon_e.addr));
                        chk("write_data", write_data, mon_e.data);
                    end else if (mon_kind == K_START_R) begin
                        chk("read_base_addr", DW'(read_base_addr), DW'(mon_e.addr));
                    end else begin
                        chk("rsp_is_read_error", DW'({rsp_is_read, rsp_error}),
                            DW'({mon_e.is_read, mon_e.err}));
                    end
                end
            end
        end
    end

    logic [DW-1:0] pat;
    int            wait_cyc;
    logic          seen;

    initial begin
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'(i * 8 + 3);

        // Reset state
        do_reset;
        chk("reset_busy", DW'(busy), '0);
        chk("reset_pulses", DW'({start_write_txn, start_read_txn, rsp_valid, rsp_is_read,
                                 rsp_error, timeout_err, wr_req_ready, rd_req_ready}), '0);
        chk("reset_addr", DW'({write_base_addr, read_base_addr}), '0);
        chk("reset_data", write_data, '0);

        // Single write, with a stray txn_done in ISSUE that must be ignored
        push_start(K_START_W, 32'h4000_0000, pat);
        push_rsp(1'b0, 1'b0);
        wr_req_valid = 1'b1; wr_req_addr = 32'h4000_0000; wr_req_data = pat;
        #1;
        chk("single_wr_ready", DW'({rd_req_ready, wr_req_ready}), DW'(2'b01));
        tick;
        wr_req_valid = 1'b0; wr_req_addr = 32'hDEAD_BEEF; wr_req_data = '1;
        chk("single_start_w", DW'(start_write_txn), DW'(1'b1));
        txn_done = 1'b1;
        tick;
        txn_done = 1'b0;
        chk("start_one_cycle", DW'({start_write_txn, busy}), DW'(2'b01));
        tick;
        chk("wait_hold_addr", DW'(write_base_addr), DW'(32'h4000_0000));
        chk("wait_hold_data", write_data, pat);
        chk("wait_no_rsp", DW'(rsp_valid), '0);
        complete(1'b0);
        chk("single_idle", DW'(busy), '0);

        // Simultaneous requests after reset: write wins, read follows after RESP
        do_reset;
        push_start(K_START_W, 32'h1000_0000, ~pat);
        push_rsp(1'b0, 1'b0);
        push_start(K_START_R, 32'h4000_0000, '0);
        push_rsp(1'b1, 1'b0);
        wr_req_valid = 1'b1; wr_req_addr = 32'h1000_0000; wr_req_data = ~pat;
        rd_req_valid = 1'b1; rd_req_addr = 32'h4000_0000;
        #1;
        chk("tie_first_write", DW'({rd_req_ready, wr_req_ready}), DW'(2'b01));
        tick;
        wr_req_valid = 1'b0;
        chk("rd_wait_issue", DW'(rd_req_ready), '0);
        tick;
        chk("rd_wait_wait", DW'(rd_req_ready), '0);
        txn_done = 1'b1;
        tick;
        txn_done = 1'b0;
        chk("rd_wait_resp", DW'({rsp_valid, rd_req_ready}), DW'(2'b10));
        tick;
        chk("rd_grant_after_resp", DW'({rd_req_ready, busy}), DW'(2'b10));
        tick;
        rd_req_valid = 1'b0;
        tick;
        complete(1'b0);

        // Both requesters held valid: strict W,R alternation
        wr_req_valid = 1'b1; rd_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_req_addr = 32'h2000_0000 + 32'(i * 256);
            rd_req_addr = 32'h3000_0000 + 32'(i * 256);
            wr_req_data = {16{32'(i + 100)}};
            #1;
            if (i % 2 == 0) begin
                chk("alt_grant", DW'({rd_req_ready, wr_req_ready}), DW'(2'b01));
                push_start(K_START_W, wr_req_addr, wr_req_data);
                push_rsp(1'b0, 1'b0);
            end else begin
                chk("alt_grant", DW'({rd_req_ready, wr_req_ready}), DW'(2'b10));
                push_start(K_START_R, rd_req_addr, '0);
                push_rsp(1'b1, 1'b0);
            end
            tick;
            tick;
            complete(1'b0);
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;

        // Error response, then a clean transaction
        push_start(K_START_W, 32'h5000_0000, pat);
        push_rsp(1'b0, 1'b1);
        wr_req_valid = 1'b1; wr_req_addr = 32'h5000_0000; wr_req_data = pat;
        tick;
        wr_req_valid = 1'b0;
        tick;
        complete(1'b1);
        push_start(K_START_R, 32'h6000_0000, '0);
        push_rsp(1'b1, 1'b0);
        rd_req_valid = 1'b1; rd_req_addr = 32'h6000_0000;
        tick;
        rd_req_valid = 1'b0;
        tick;
        complete(1'b0);

        // Reset in WAIT abandons the transaction silently
        push_start(K_START_W, 32'h7000_0000, pat);
        wr_req_valid = 1'b1; wr_req_addr = 32'h7000_0000; wr_req_data = pat;
        tick;
        wr_req_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_wait_busy", DW'(busy), '0);
        chk("rst_wait_outputs", DW'({start_write_txn, start_read_txn, rsp_valid, rsp_is_read,
                                     rsp_error, timeout_err, write_base_addr}), '0);
        txn_done = 1'b1;
        tick;
        txn_done = 1'b0;
        repeat (3) tick;
        chk("rst_wait_idle", DW'(busy), '0);

        // Withheld completion
        push_start(K_START_W, 32'h7100_0000, pat);
        wr_req_valid = 1'b1; wr_req_addr = 32'h7100_0000; wr_req_data = pat;
        tick;
        wr_req_valid = 1'b0;
        tick;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
        push_rsp(1'b0, 1'b1);
        seen = 1'b0;
        wait_cyc = 0;
        for (int k = 0; k < TO + 8 && !seen; k++) begin
            tick;
            wait_cyc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("timeout_rsp_seen", DW'(seen), DW'(1'b1));
        chk("timeout_latency", DW'(wait_cyc), DW'(TO));
        chk("timeout_err_set", DW'(timeout_err), DW'(1'b1));
        repeat (4) tick;
        push_start(K_START_R, 32'h7200_0000, '0);
        push_rsp(1'b1, 1'b0);
        rd_req_valid = 1'b1; rd_req_addr = 32'h7200_0000;
        tick;
        rd_req_valid = 1'b0;
        tick;
        complete(1'b0);
        chk("timeout_err_sticky", DW'(timeout_err), DW'(1'b1));
        do_reset;
        chk("timeout_err_cleared", DW'(timeout_err), '0);
`else
        repeat (60) tick;
        chk("no_timeout_busy", DW'({busy, rsp_valid}), DW'(2'b10));
        chk("no_timeout_err", DW'(timeout_err), '0);
        do_reset;
        chk("no_timeout_reset", DW'(busy), '0);
`endif

        repeat (2) tick;
        chk("queue_empty", DW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
